regfile_wr_arb: RTL
===================

// Module: regfile_wr_arb
// PURPOSE
//  Shares the single regfile write port (we3/wa3/wd3) between the in-order pipeline
//  writeback and a multi-cycle long-op unit (mult/div). Long-op results are queued
//  in a small FIFO and drained when the pipeline does not write. A scoreboard tracks
//  destinations of in-flight long ops for decode hazard checks. Sits between WB and regfile.
// PARAMETERS
//  DEPTH      4   long-op result FIFO entries (power of 2, >=2)
//  MAX_DEFER  8   consecutive deferred cycles with FIFO non-empty before stall_req
// PORTS
//  clk         in   1   clock; all state on posedge
//  rst_n       in   1   synchronous active-low reset
//  pipe_we     in   1   pipeline WB write enable
//  pipe_wa     in   5   pipeline WB destination
//  pipe_wd     in   32  pipeline WB data
//  iss_valid   in   1   long op issued this cycle (decode)
//  iss_wa      in   5   long-op destination
//  iss_ready   out  1   comb: !busy[iss_wa] && inflight < DEPTH
//  lop_valid   in   1   long-op result valid
//  lop_wa      in   5   result destination
//  lop_wd      in   32  result data
//  lop_ready   out  1   comb: FIFO not full
//  chk_ra1     in   5   decode source 1
//  chk_ra2     in   5   decode source 2
//  chk_hazard  out  1   comb: busy[chk_ra1] | busy[chk_ra2]
//  stall_req   out  1   registered: pipeline must hold WB (pipe_we=0) next cycle
//  rf_we       out  1   to regfile we3
//  rf_wa       out  5   to regfile wa3
//  rf_wd       out  32  to regfile wd3
// BEHAVIOUR
//  - Reset: FIFO empty, busy=0, inflight=0, defer_cnt=0, stall_req=0; rf_we=0 while rst_n=0.
//  - Port select (comb): pipe_we=1 -> rf_* = pipe_*; else FIFO non-empty -> rf_* = head,
//    pop; else rf_we=0. Pipeline never waits on the arbiter except via stall_req.
//  - Push when lop_valid&&lop_ready; result visible on rf_* no earlier than next cycle.
//  - Push and pop same cycle with FIFO full: lop_ready still 0 (no pass-through).
//  - Scoreboard: iss_valid&&iss_ready&&iss_wa!=0 sets busy[iss_wa], inflight++.
//    Pop of entry wa clears busy[wa], inflight--. Same-cycle set of reg X and clear
//    of reg X: set wins (new op). busy[0] constant 0; inflight unchanged by wa=0 ops.
//  - lop_wa==0 results are accepted but discarded (never pushed, never write).
//  - inflight<=DEPTH guarantees every issued op has a FIFO slot; lop_ready=0 is a
//    backpressure error condition only under misuse.
//  - defer_cnt: increments when FIFO non-empty && pipe_we=1; clears on pop or empty;
//    saturates. stall_req <= (defer_cnt==MAX_DEFER-1 && deferral this cycle); held
//    until a pop occurs. pipe_we=1 while stall_req=1 is a protocol error (assert).
//  - Pipeline write to a busy register: protocol error (assert); arbiter still writes.
//  - FIFO pointers log2(DEPTH) bits, count log2(DEPTH)+1 bits, wrap naturally.
// STRUCTURE
//  - Package regfile_pkg: reg_addr_t (logic[4:0]), word_t (logic[31:0]),
//    wr_req_t struct {we, wa, wd}, REG_ZERO constant.
//  - Sub-module wr_fifo (DEPTH x {wa,wd}, push/pop/full/empty/count); scoreboard,
//    defer counter and mux stay in top.
// TESTING
//  1 Reset: rst_n=0 two cycles with lop_valid=1 -> rf_we=0, lop_ready=1, busy=0, no push.
//  2 Idle drain: issue wa=5, result 0x1234 next cycle, pipe_we=0 -> rf_we=1,wa=5,wd=0x1234
//    one cycle later; chk_ra1=5 hazard=1 until that cycle, 0 after.
//  3 Priority: FIFO holds wa=3; pipe_we=1 wa=7 wd=0xAA -> rf writes 7/0xAA, FIFO kept;
//    pipe_we=0 next -> rf writes 3.
//  4 Starvation: FIFO non-empty, pipe_we=1 for 8 cycles -> stall_req=1 after 8th;
//    bench drops pipe_we -> pop, stall_req=0 next cycle.
//  5 Full/inflight: 4 issues to regs 1-4 -> iss_ready=0 for 5th; issue to busy reg 2
//    -> iss_ready=0; pop of reg 1 with same-cycle issue reg 1 -> busy[1] stays 1.
//  6 Zero reg: issue wa=0 and result wa=0 -> no busy bit, no rf write, inflight unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the regfile write-port arbiter: register address/data words
// and the write request bundle driven onto the regfile write port.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0]     word_t;

  typedef struct packed {
    logic      we;
    reg_addr_t wa;
    word_t     wd;
  } wr_req_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/wr_fifo.sv
// Small FIFO holding long-op results {wa, wd} until the regfile write port is free.
// The head is read combinationally so it can be written and popped in the same cycle.
module wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push, do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  // Pointers are exactly log2(DEPTH) bits, so they wrap without explicit compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end
endmodule

// File: rtl/regfile_wr_arb.sv
// Arbitrates the single regfile write port between pipeline writeback (priority)
// and queued long-op results; tracks in-flight long-op destinations for decode.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_DEFER = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_wd,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wa,
  output logic        iss_ready,
  input  logic        lop_valid,
  input  logic [4:0]  lop_wa,
  input  logic [31:0] lop_wd,
  output logic        lop_ready,
  input  logic [4:0]  chk_ra1,
  input  logic [4:0]  chk_ra2,
  output logic        chk_hazard,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(MAX_DEFER + 1);

  logic [NUM_REGS-1:0] busy_reg, busy_next;
  logic [CW-1:0]       inflight_reg, inflight_next;
  logic [CW-1:0]       fifo_count;
  logic [DW-1:0]       defer_cnt_reg, defer_cnt_next;
  logic                stall_reg, stall_next;
  logic                fifo_full, fifo_empty;
  logic                push, pop, set_en, deferral;
  logic [REG_ADDR_W+WORD_W-1:0] fifo_dout;
  reg_addr_t           head_wa;
  word_t               head_wd;
  wr_req_t             wr_sel;

  assign {head_wa, head_wd} = fifo_dout;

  assign lop_ready  = !fifo_full;
  assign iss_ready  = !busy_reg[iss_wa] && (inflight_reg < CW'(DEPTH));
  assign chk_hazard = busy_reg[chk_ra1] | busy_reg[chk_ra2];
  assign stall_req  = stall_reg;

  // Results for r0 are accepted but dropped: they never occupy a slot or write.
  assign push     = lop_valid && lop_ready && (lop_wa != REG_ZERO);
  assign pop      = rst_n && !pipe_we && !fifo_empty;
  assign set_en   = iss_valid && iss_ready && (iss_wa != REG_ZERO);
  assign deferral = pipe_we && !fifo_empty;

  wr_fifo #(
    .DEPTH (DEPTH),
    .W     (REG_ADDR_W + WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({lop_wa, lop_wd}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    wr_sel = '0;
    if (rst_n) begin
      if (pipe_we)          wr_sel = '{we: 1'b1, wa: pipe_wa, wd: pipe_wd};
      else if (!fifo_empty) wr_sel = '{we: 1'b1, wa: head_wa, wd: head_wd};
    end
  end

  assign rf_we = wr_sel.we;
  assign rf_wa = wr_sel.wa;
  assign rf_wd = wr_sel.wd;

  // Issue wins over a same-cycle retire of the same register: it is a newer op.
  genvar gi;
  assign busy_next[0] = 1'b0;
  for (gi = 1; gi < NUM_REGS; gi++) begin : g_busy
    assign busy_next[gi] = (set_en && iss_wa == reg_addr_t'(gi)) ? 1'b1 :
                           (pop && head_wa == reg_addr_t'(gi))   ? 1'b0 :
                           busy_reg[gi];
  end

  assign inflight_next = inflight_reg + CW'(set_en) - CW'(pop);

  always_comb begin
    defer_cnt_next = defer_cnt_reg;
    stall_next     = stall_reg;
    if (pop || fifo_empty)
      defer_cnt_next = '0;
    else if (deferral && defer_cnt_reg != DW'(MAX_DEFER))
      defer_cnt_next = defer_cnt_reg + DW'(1);
    // Once raised, stall holds until the queue actually gets a write slot.
    if (deferral && defer_cnt_reg == DW'(MAX_DEFER - 1))
      stall_next = 1'b1;
    else if (pop)
      stall_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg      <= '0;
      inflight_reg  <= '0;
      defer_cnt_reg <= '0;
      stall_reg     <= 1'b0;
    end else begin
      busy_reg      <= busy_next;
      inflight_reg  <= inflight_next;
      defer_cnt_reg <= defer_cnt_next;
      stall_reg     <= stall_next;
    end
  end

  a_no_we_during_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(pipe_we && stall_req));
  a_no_pipe_write_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(pipe_we && busy_reg[pipe_wa]));
  a_queue_within_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    inflight_reg >= fifo_count);
endmodule
